// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipeline_pkg;

  localparam int REG_KEY_W = 5;
  localparam int NUM_REGS  = 32;

  // Controller FSM: normal issue, or parked while a multi-cycle MDU op runs.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // One-hot mask for a register key.
  function automatic logic [NUM_REGS-1:0] key_mask(input logic [REG_KEY_W-1:0] key);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[key] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_controller_scoreboard.sv
// Pending-load scoreboard: one busy bit per register key.
// A set and a clear of the same key in one cycle leave the bit set (the new
// load owns the register). Key 0 is hardwired idle.
module scoreboard
  import pipeline_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_KEY_W-1:0] set_key,
  input  logic                 clr_en,
  input  logic [REG_KEY_W-1:0] clr_key,
  output logic [NUM_REGS-1:0]  busy
);

  localparam logic [NUM_REGS-1:0] KEY0_MASK = NUM_REGS'(1);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_next;

  // Next busy vector: clear first, then set, so a same-key set wins.
  always_comb begin
    set_mask  = set_en ? key_mask(set_key) : '0;
    clr_mask  = clr_en ? key_mask(clr_key) : '0;
    busy_next = ((busy_q & ~clr_mask) | set_mask) & ~KEY0_MASK;
  end

  // Busy register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_next;
  end

  assign busy = busy_q & ~KEY0_MASK;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline control: load-use hazard detection via a pending-load scoreboard,
// branch flush, multi-cycle MDU wait with timeout, and a stall counter.
// Handshake: mdu_start is a single-cycle launch pulse; the controller then
// holds the front end until mdu_done is seen high for one cycle (or the wait
// times out). load_done/load_done_key is a one-cycle release of a pending key.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int PERF_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_KEY_W-1:0] id_src1_key,
  input  logic [REG_KEY_W-1:0] id_src2_key,
  input  logic [REG_KEY_W-1:0] id_rd_key,
  input  logic                 id_rd_en,
  input  logic                 id_is_load,
  input  logic                 id_is_mdu,
  input  logic                 ex_branch_taken,
  input  logic                 load_done,
  input  logic [REG_KEY_W-1:0] load_done_key,
  input  logic                 mdu_done,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_ex_bubble,
  output logic                 if_id_flush,
  output logic                 mdu_start,
  output logic                 mdu_timeout_err,
  output logic [NUM_REGS-1:0]  sb_busy,
  output logic [PERF_W-1:0]    stall_count
);

  localparam int CNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             hazard;
  logic             issue;
  logic             sb_set;

  // A key is blocking if nonzero, pending, and not being released this cycle.
  function automatic logic key_blocked(input logic [NUM_REGS-1:0]  busy,
                                       input logic [REG_KEY_W-1:0] key,
                                       input logic                 done,
                                       input logic [REG_KEY_W-1:0] done_key);
    return (key != '0) && busy[key] && !(done && (key == done_key));
  endfunction

  // Hazard/issue decode and combinational pipeline controls.
  always_comb begin
    hazard       = 1'b0;
    issue        = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    mdu_start    = 1'b0;
    sb_set       = 1'b0;
    if (reset) begin
      if (state == RUN) begin
        hazard = id_valid &&
                 (key_blocked(sb_busy, id_src1_key, load_done, load_done_key) ||
                  key_blocked(sb_busy, id_src2_key, load_done, load_done_key) ||
                  key_blocked(sb_busy, id_rd_key,   load_done, load_done_key));
        issue  = id_valid && !hazard && !ex_branch_taken;
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hazard) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        mdu_start = issue && id_is_mdu;
        sb_set    = issue && id_is_load && id_rd_en && (id_rd_key != '0);
      end else begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

  scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (sb_set),
    .set_key (id_rd_key),
    .clr_en  (load_done),
    .clr_key (load_done_key),
    .busy    (sb_busy)
  );

  // MDU wait FSM with timeout counter and sticky abort flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mdu_timeout_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mdu_start) begin
            state    <= MDU_WAIT;
            wait_cnt <= '0;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state           <= RUN;
            mdu_timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (!reset)                          stall_count <= '0;
    else if (pc_stall && !(&stall_count)) stall_count <= stall_count + PERF_W'(1);
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with an expected-value queue.
module tb_pipeline_controller;

  localparam int PERF_W      = 16;
  localparam int MDU_TIMEOUT = 64;

  // ctrl = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, mdu_start, mdu_timeout_err}
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b111000;
  localparam logic [5:0] C_FLUSH = 6'b001100;
  localparam logic [5:0] C_START = 6'b000010;
  localparam logic [5:0] C_ERR   = 6'b000001;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [4:0]        id_src1_key;
  logic [4:0]        id_src2_key;
  logic [4:0]        id_rd_key;
  logic              id_rd_en;
  logic              id_is_load;
  logic              id_is_mdu;
  logic              ex_branch_taken;
  logic              load_done;
  logic [4:0]        load_done_key;
  logic              mdu_done;
  logic              pc_stall;
  logic              if_id_stall;
  logic              id_ex_bubble;
  logic              if_id_flush;
  logic              mdu_start;
  logic              mdu_timeout_err;
  logic [31:0]       sb_busy;
  logic [PERF_W-1:0] stall_count;
  logic [5:0]        ctrl;

  logic [31:0] exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          exp_cnt     = 0;

  pipeline_controller #(.MDU_TIMEOUT(MDU_TIMEOUT), .PERF_W(PERF_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_src1_key     (id_src1_key),
    .id_src2_key     (id_src2_key),
    .id_rd_key       (id_rd_key),
    .id_rd_en        (id_rd_en),
    .id_is_load      (id_is_load),
    .id_is_mdu       (id_is_mdu),
    .ex_branch_taken (ex_branch_taken),
    .load_done       (load_done),
    .load_done_key   (load_done_key),
    .mdu_done        (mdu_done),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .mdu_start       (mdu_start),
    .mdu_timeout_err (mdu_timeout_err),
    .sb_busy         (sb_busy),
    .stall_count     (stall_count)
  );

  assign ctrl = {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, mdu_start, mdu_timeout_err};

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic clear_inputs();
    id_valid        = 1'b0;
    id_src1_key     = '0;
    id_src2_key     = '0;
    id_rd_key       = '0;
    id_rd_en        = 1'b0;
    id_is_load      = 1'b0;
    id_is_mdu       = 1'b0;
    ex_branch_taken = 1'b0;
    load_done       = 1'b0;
    load_done_key   = '0;
    mdu_done        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    clear_inputs();
    id_valid   = 1'b1;
    id_is_load = 1'b1;
    id_rd_en   = 1'b1;
    id_rd_key  = rd;
  endtask

  task automatic drive_done(input logic [4:0] key);
    clear_inputs();
    load_done     = 1'b1;
    load_done_key = key;
  endtask

  // Scoreboard: pop the oldest expectation and compare.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s observed=0x%08h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, e);
      end
    end
  endtask

  // Hold current inputs for one cycle; check controls mid-cycle.
  task automatic cyc(input string tag, input logic [5:0] e);
    exp_q.push_back({26'b0, e});
    @(negedge clk);
    check(tag, {26'b0, ctrl});
    tick();
  endtask

  // Check registered state just after an edge.
  task automatic regs(input string tag, input logic [31:0] e_sb, input int e_cnt);
    exp_q.push_back(e_sb);
    check({tag, "_sb"}, sb_busy);
    exp_q.push_back(32'(e_cnt));
    check({tag, "_cnt"}, {16'b0, stall_count});
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    exp_cnt = 0;
  endtask

  // Directed sequence
  initial begin
    logic [4:0] k;
    clear_inputs();
    reset = 1'b0;
    tick();

    // Controls forced low during reset despite active inputs
    id_valid = 1'b1; id_is_mdu = 1'b1; ex_branch_taken = 1'b1; id_src1_key = 5'd5;
    cyc("rst_ctrl_a", C_IDLE);
    cyc("rst_ctrl_b", C_IDLE);
    regs("rst", 32'h0, 0);
    reset = 1'b1;
    clear_inputs();
    cyc("idle", C_IDLE);

    // Load x5, dependent reader stalls, same-cycle release lets it issue
    drive_load(5'd5);
    cyc("ld5_issue", C_IDLE);
    regs("ld5", 32'h20, 0);
    clear_inputs(); id_valid = 1'b1; id_src1_key = 5'd5;
    cyc("raw5_a", C_STALL); regs("raw5_a", 32'h20, 1);
    cyc("raw5_b", C_STALL); regs("raw5_b", 32'h20, 2);
    load_done = 1'b1; load_done_key = 5'd5;
    cyc("raw5_release", C_IDLE); regs("raw5_release", 32'h0, 2);
    exp_cnt = 2;

    // load_done for an idle key
    drive_done(5'd7);
    cyc("done_idle", C_IDLE); regs("done_idle", 32'h0, exp_cnt);

    // Load to x0 never marks busy; x0 reader never stalls
    drive_load(5'd0);
    cyc("ld0", C_IDLE); regs("ld0", 32'h0, exp_cnt);
    clear_inputs(); id_valid = 1'b1; id_rd_en = 1'b1;
    cyc("rd0", C_IDLE); regs("rd0", 32'h0, exp_cnt);

    // Randomised key: set, src2 hazard, release
    for (int i = 0; i < 4; i++) begin
      k = 5'($urandom_range(1, 31));
      drive_load(k);
      cyc("rnd_ld", C_IDLE); regs("rnd_ld", 32'h1 << k, exp_cnt);
      clear_inputs(); id_valid = 1'b1; id_src2_key = k;
      cyc("rnd_raw", C_STALL); exp_cnt++; regs("rnd_raw", 32'h1 << k, exp_cnt);
      drive_done(k);
      cyc("rnd_done", C_IDLE); regs("rnd_done", 32'h0, exp_cnt);
    end

    // WAW on rd, then reload x9 while its data returns: bit stays set
    drive_load(5'd9);
    cyc("ld9", C_IDLE); regs("ld9", 32'h200, exp_cnt);
    clear_inputs(); id_valid = 1'b1; id_rd_en = 1'b1; id_rd_key = 5'd9;
    cyc("waw9", C_STALL); exp_cnt++; regs("waw9", 32'h200, exp_cnt);
    drive_load(5'd9); load_done = 1'b1; load_done_key = 5'd9;
    cyc("ld9_setclr", C_IDLE); regs("ld9_setclr", 32'h200, exp_cnt);
    drive_done(5'd9);
    cyc("done9", C_IDLE); regs("done9", 32'h0, exp_cnt);

    // Branch overrides hazard; flushed load does not set scoreboard
    drive_load(5'd3);
    cyc("ld3", C_IDLE); regs("ld3", 32'h8, exp_cnt);
    drive_load(5'd4); id_src1_key = 5'd3; ex_branch_taken = 1'b1;
    cyc("br_flush", C_FLUSH); regs("br_flush", 32'h8, exp_cnt);
    drive_done(5'd3);
    cyc("done3", C_IDLE); regs("done3", 32'h0, exp_cnt);

    // MDU op: 3 wait cycles then mdu_done, stall_count reaches 4
    do_reset();
    regs("rst2", 32'h0, 0);
    drive_load(5'd6);
    cyc("ld6", C_IDLE); regs("ld6", 32'h40, 0);
    clear_inputs(); id_valid = 1'b1; id_is_mdu = 1'b1;
    cyc("mdu_issue", C_START); regs("mdu_issue", 32'h40, 0);
    cyc("mdu_w1", C_STALL); regs("mdu_w1", 32'h40, 1);
    drive_done(5'd6); ex_branch_taken = 1'b1;
    cyc("mdu_w2", C_STALL); regs("mdu_w2", 32'h0, 2);
    clear_inputs();
    cyc("mdu_w3", C_STALL); regs("mdu_w3", 32'h0, 3);
    mdu_done = 1'b1;
    cyc("mdu_done", C_STALL); regs("mdu_done", 32'h0, 4);
    cyc("mdu_done_run", C_IDLE); regs("mdu_done_run", 32'h0, 4);
    clear_inputs();
    cyc("mdu_idle", C_IDLE);

    // MDU timeout: 64 wait cycles, back to RUN with sticky error
    do_reset();
    id_valid = 1'b1; id_is_mdu = 1'b1;
    cyc("to_issue", C_START);
    clear_inputs();
    for (int i = 0; i < MDU_TIMEOUT; i++) cyc("to_wait", C_STALL);
    regs("to_back", 32'h0, MDU_TIMEOUT);
    cyc("to_err", C_ERR);
    mdu_done = 1'b1;
    cyc("to_err_sticky", C_ERR); regs("to_err_sticky", 32'h0, MDU_TIMEOUT);

    // Reset in MDU_WAIT with x5 pending discards everything
    do_reset();
    drive_load(5'd5);
    cyc("r_ld5", C_IDLE); regs("r_ld5", 32'h20, 0);
    clear_inputs(); id_valid = 1'b1; id_is_mdu = 1'b1;
    cyc("r_issue", C_START);
    cyc("r_wait", C_STALL); regs("r_wait", 32'h20, 1);
    reset = 1'b0; ex_branch_taken = 1'b1;
    cyc("r_in_reset", C_IDLE); regs("r_in_reset", 32'h0, 0);
    reset = 1'b1; clear_inputs();
    cyc("r_after", C_IDLE); regs("r_after", 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MDU_TIMEOUT, default 64, MDU wait cycles before abort.
REQ-002 SHALL have parameter PERF_W, default 16, width of stall performance counter.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have id_valid  input  1  decode stage holds a valid instruction.
REQ-006 SHALL have id_src1_key, id_src2_key, id_rd_key  input  5 each  decode register keys.
REQ-007 SHALL have id_rd_en  input  1  decode instruction writes rd.
REQ-008 SHALL have id_is_load, id_is_mdu  input  1 each  variable-latency load / multi-cycle MDU op.
REQ-009 SHALL have ex_branch_taken  input  1  EX redirects PC this cycle.
REQ-010 SHALL have load_done, load_done_key  input  1/5  memory returns load data for key.
REQ-011 SHALL have mdu_done  input  1  MDU result ready.
REQ-012 SHALL have pc_stall, if_id_stall, id_ex_bubble, if_id_flush  output  1 each  pipeline control.
REQ-013 SHALL have mdu_start  output  1  one-cycle MDU launch pulse.
REQ-014 SHALL have mdu_timeout_err  output  1  sticky MDU abort flag.
REQ-015 SHALL have sb_busy  output  32  scoreboard, bit n = load pending to key n.
REQ-016 SHALL have stall_count  output  PERF_W  saturating count of cycles with pc_stall high.

Function
REQ-017 FSM states: RUN, MDU_WAIT.
REQ-018 hazard (RUN) = id_valid and any of src1/src2/rd key nonzero with sb_busy bit set, excluding the key equal to load_done_key while load_done is high (same-cycle release, no stall).
REQ-019 issue = RUN and id_valid and not hazard and not ex_branch_taken.
REQ-020 In RUN: hazard drives pc_stall=if_id_stall=id_ex_bubble=1; if_id_flush=0.
REQ-021 ex_branch_taken in RUN drives if_id_flush=1 and id_ex_bubble=1, pc_stall=if_id_stall=0, and overrides hazard; the flushed instruction does not issue.
REQ-022 Issue of a load with id_rd_en and id_rd_key!=0 sets sb_busy[id_rd_key] at the next edge.
REQ-023 load_done clears sb_busy[load_done_key] at the next edge; set and clear of the same key in one cycle leaves the bit set.
REQ-024 sb_busy[0] SHALL always read 0; load_done for an idle key has no effect.
REQ-025 Issue of an MDU op asserts mdu_start combinationally that cycle and moves RUN->MDU_WAIT at the next edge.
REQ-026 In MDU_WAIT: pc_stall=if_id_stall=id_ex_bubble=1; ex_branch_taken and decode inputs are ignored; scoreboard continues to accept load_done.
REQ-027 MDU_WAIT->RUN at the edge after mdu_done=1; wait counter resets on entry to MDU_WAIT.
REQ-028 Wait counter reaching MDU_TIMEOUT-1 without mdu_done forces MDU_WAIT->RUN and sets mdu_timeout_err until reset.
REQ-029 mdu_done in RUN is ignored.
REQ-030 stall_count increments on each cycle with pc_stall=1, saturating at all-ones.
REQ-031 All control outputs are combinational from state and inputs; no added latency.

Reset
REQ-032 While reset=0 at an edge: state=RUN, sb_busy=0, wait counter=0, stall_count=0, mdu_timeout_err=0.
REQ-033 While reset=0, all control outputs and mdu_start SHALL be 0 regardless of inputs.
REQ-034 Reset mid-MDU_WAIT or with pending loads discards all state; no mdu_start is reissued.

Structure
REQ-035 Shared package pipeline_pkg SHALL hold REG_KEY_W=5, NUM_REGS=32 and the FSM state enum.
REQ-036 Scoreboard SHALL be a sub-module named scoreboard (set/clear ports, busy vector, key-0 masking).

Verification
REQ-037 Load to x5 issues, next instr reads x5 -> stall 1..N cycles; load_done key 5 -> no stall that cycle, instr issues.
REQ-038 Load to x0 issues -> sb_busy stays 0, dependent x0 reader never stalls.
REQ-039 MDU op issues -> mdu_start one cycle, 3 stall cycles, mdu_done -> RUN next edge, stall_count=4.
REQ-040 MDU op, mdu_done never arrives -> 64 stall cycles, return to RUN, mdu_timeout_err=1.
REQ-041 ex_branch_taken with hazard present -> if_id_flush=1, id_ex_bubble=1, pc_stall=0, no scoreboard set.
REQ-042 reset=0 during MDU_WAIT with sb_busy=0x0000_0020 -> RUN, sb_busy=0, all outputs 0 next cycle.
